// File: rtl/aes_text_out.sv
// Final-round output collector: XORs state bytes with last-round key bytes and packs them MSB-first.
// Optional macro AES_TEXT_OUT_CLR_EN wipes text_out when the consumer acknowledges the block.
module aes_text_out #(
  parameter int NB = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            byte_vld,
  input  logic [7:0]      sa_i,
  input  logic [7:0]      w_i,
  input  logic            out_ack,
  output logic [8*NB-1:0] text_out,
  output logic            done,
  output logic            busy
);

  localparam int            CW     = $clog2(NB);
  localparam logic [CW-1:0] LAST_C = CW'(NB - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t          state_r;
  logic [CW-1:0]   cnt_r;
  logic [8*NB-1:0] text_r;
  logic            done_r;
  logic            busy_r;
  logic [7:0]      byte_s;

  // Output byte is the final AddRoundKey of the incoming state byte.
  always_comb begin
    byte_s = sa_i ^ w_i;
  end

  // Control FSM, byte counter and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      cnt_r   <= '0;
      text_r  <= '0;
      done_r  <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            state_r <= COLLECT;
            cnt_r   <= '0;
            busy_r  <= 1'b1;
          end
        end
        COLLECT: begin
          if (byte_vld) begin
            text_r[8*NB-1-8*int'(cnt_r) -: 8] <= byte_s;
            // The last byte parks the counter instead of letting it wrap into another write.
            if (cnt_r == LAST_C) begin
              state_r <= DONE;
              cnt_r   <= '0;
              done_r  <= 1'b1;
            end else begin
              cnt_r <= cnt_r + CW'(1);
            end
          end
        end
        DONE: begin
          if (out_ack) begin
            state_r <= IDLE;
            done_r  <= 1'b0;
            busy_r  <= 1'b0;
`ifdef AES_TEXT_OUT_CLR_EN
            text_r  <= '0;
`else
            text_r  <= text_r;
`endif
          end
        end
        default: begin
          state_r <= IDLE;
          cnt_r   <= '0;
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign text_out = text_r;
  assign done     = done_r;
  assign busy     = busy_r;

endmodule

// File: doc/aes_text_out.md
AES_TEXT_OUT -- requirements
Module: aes_text_out

Interface
REQ-001 Parameter NB, default 16, number of state bytes per block; the byte counter SHALL be $clog2(NB) bits wide.
REQ-002 clk  input  1  rising-edge clock; all state SHALL update only on posedge clk.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  final-round output phase begins; sampled only in IDLE.
REQ-005 byte_vld  input  1  sa_i/w_i carry a valid byte this cycle; sampled only in COLLECT.
REQ-006 sa_i  input  8  final-round state byte.
REQ-007 w_i  input  8  matching last-round key byte.
REQ-008 out_ack  input  1  consumer has taken text_out; sampled only in DONE.
REQ-009 text_out  output  8*NB  assembled ciphertext/plaintext, registered.
REQ-010 done  output  1  text_out complete and stable, registered.
REQ-011 busy  output  1  high whenever state is not IDLE, registered or decoded from the state register.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, COLLECT and DONE.
REQ-013 In IDLE with start=1, the FSM SHALL move to COLLECT next cycle and clear the byte counter to 0.
REQ-014 In IDLE, byte_vld SHALL be ignored, including when start=1 in the same cycle.
REQ-015 In COLLECT with byte_vld=1, the block SHALL write text_out[8*NB-1-8*cnt -: 8] <= sa_i ^ w_i and increment cnt; byte 0 lands in the MSB byte.
REQ-016 In COLLECT with byte_vld=0, text_out and cnt SHALL hold.
REQ-017 Stall cycles between bytes SHALL be unlimited and SHALL NOT affect the result.
REQ-018 On acceptance of byte NB-1, the FSM SHALL enter DONE, and done SHALL assert on the following cycle; latency from the last byte_vld to done=1 is 1 cycle.
REQ-019 The counter SHALL NOT wrap into a 17th write; no write to text_out occurs outside COLLECT.
REQ-020 In DONE, text_out SHALL hold, and done SHALL stay 1 until out_ack=1.
REQ-021 In DONE with out_ack=1, the FSM SHALL return to IDLE, and done SHALL be 0 on the next cycle.
REQ-022 start in COLLECT or DONE SHALL be ignored, including in the same cycle as out_ack; a new block requires start in IDLE.
REQ-023 byte_vld in DONE SHALL be ignored, and out_ack outside DONE SHALL be ignored.

Reset
REQ-024 With rst=1 at a clock edge, the next state SHALL be IDLE, with cnt=0, text_out=0, done=0 and busy=0, regardless of other inputs.
REQ-025 rst SHALL take priority over start, byte_vld and out_ack in every state, including mid-COLLECT; a partial block SHALL be discarded.

Configuration
REQ-026 The block SHALL support exactly one compile-time option, the macro AES_TEXT_OUT_CLR_EN.
REQ-027 When AES_TEXT_OUT_CLR_EN is defined, text_out SHALL be cleared to 0 on the same edge that leaves DONE via out_ack, so no key-derived data remains.
REQ-028 When AES_TEXT_OUT_CLR_EN is not defined, text_out SHALL retain the last block until the first byte write of the next block or until rst.

Verification
REQ-029 Basic block: rst, start, then 16 back-to-back bytes with sa_i=i and w_i=8'hA5 -> done 1 cycle after the last byte, text_out = bytes (i^8'hA5) MSB-first, i.e. 128'hA5A4A7A6_A1A0A3A2_ADACAFAE_A9A8ABAA.
REQ-030 Stalled input: the same data with byte_vld deasserted for 3 cycles after bytes 0, 7 and 15 -> identical text_out; done asserted only after byte 15.
REQ-031 Handshake hold: out_ack held 0 for 20 cycles in DONE while byte_vld=1 and start=1 toggle -> done=1 and text_out unchanged; out_ack=1 -> done=0 next cycle and busy=0.
REQ-032 Reset mid-op: rst after byte 5 -> text_out=0, done=0, busy=0; a following full block yields a correct result without any residue from the aborted block.
REQ-033 Start and byte collision: start=1 with byte_vld=1, sa_i=8'hFF in IDLE -> that byte not written; the first byte_vld in COLLECT lands in text_out[127:120].
REQ-034 Config: after out_ack, text_out=0 with AES_TEXT_OUT_CLR_EN defined; without it, text_out retains the previous value.
